// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the Beta ALU sequential add/compare path:
//             operation encodings, the sequencer state type and helpers.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_CMPEQ = 3'b101;
    localparam logic [2:0] OP_CMPLT = 3'b110;
    localparam logic [2:0] OP_CMPLE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of slice passes needed to cover the full operand width.
    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // SUB and all compares evaluate A-B; unlisted codes fall back to ADD.
    function automatic logic op_subtracts(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_CMPEQ) ||
               (op == OP_CMPLT) || (op == OP_CMPLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_slice.sv
`default_nettype none
// ============================================================================
//  Module   : cla_slice
//  Purpose  : Combinational SLICE-bit carry-lookahead adder built as a
//             parallel-prefix generate/propagate tree.
//  Ports    : a, b  - slice operands
//             ci    - carry in
//             s     - slice sum
//             co    - carry out
//  Revision : 1.0  initial release
// ============================================================================
module cla_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    localparam int LEVELS = $clog2(SLICE);

    logic [SLICE-1:0] w_p0;
    logic [SLICE-1:0] w_gt;
    logic [SLICE-1:0] w_pt;
    logic [SLICE-1:0] w_gn;
    logic [SLICE-1:0] w_pn;
    logic [SLICE:0]   w_c;

    // After the prefix levels, w_gt[i]/w_pt[i] are group generate/propagate
    // over bits [i:0]; the carry into bit i+1 then folds in ci directly.
    always_comb begin
        w_p0 = a ^ b;
        w_gt = a & b;
        w_pt = w_p0;
        w_gn = '0;
        w_pn = '0;
        for (int l = 0; l < LEVELS; l++) begin
            w_gn = w_gt;
            w_pn = w_pt;
            for (int i = (1 << l); i < SLICE; i++) begin
                w_gn[i] = w_gt[i] | (w_pt[i] & w_gt[i - (1 << l)]);
                w_pn[i] = w_pt[i] & w_pt[i - (1 << l)];
            end
            w_gt = w_gn;
            w_pt = w_pn;
        end
        w_c = {w_gt | (w_pt & {SLICE{ci}}), ci};
        s   = w_p0 ^ w_c[SLICE-1:0];
        co  = w_c[SLICE];
    end

endmodule
`default_nettype wire

// File: rtl/cla_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla_seq_adder
//  Purpose  : Multi-cycle add/subtract/compare sequencer. One SLICE-bit CLA
//             is reused over WIDTH/SLICE cycles, LSB slice first, with a
//             registered inter-slice carry. Produces Beta Z/V/N flags and
//             CMPEQ/CMPLT/CMPLE results.
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             in_valid/in_ready    - operand handshake (ready only in IDLE)
//             a, b, op             - operands and operation code
//             out_valid/out_ready  - result handshake (valid only in DONE)
//             y                    - sum/difference or zero-extended compare
//             z, v, n              - flags of the A+/-B computation
//  Revision : 1.0  initial release
// ============================================================================
module cla_seq_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             v,
    output logic             n
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;        // already inverted for subtracting ops
    logic [WIDTH-1:0]   r_sum;
    logic [2:0]         r_op;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_y;
    logic               r_z;
    logic               r_v;
    logic               r_n;

    logic               w_sub;
    logic               w_last;
    logic [SLICE-1:0]   w_sl_a;
    logic [SLICE-1:0]   w_sl_b;
    logic [SLICE-1:0]   w_sl_s;
    logic               w_sl_co;
    logic [WIDTH-1:0]   w_sum_full;
    logic               w_z;
    logic               w_v;
    logic               w_n;
    logic [WIDTH-1:0]   w_y;

    assign w_sub  = op_subtracts(op);
    assign w_last = (r_idx == LAST_IDX);
    assign w_sl_a = r_a[r_idx*SLICE +: SLICE];
    assign w_sl_b = r_b[r_idx*SLICE +: SLICE];

    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a  (w_sl_a),
        .b  (w_sl_b),
        .ci (r_carry),
        .s  (w_sl_s),
        .co (w_sl_co)
    );

    // Full sum as it will look after this cycle's slice is written; the
    // flags on the final pass need the top slice before it is registered.
    always_comb begin
        w_sum_full = r_sum;
        w_sum_full[r_idx*SLICE +: SLICE] = w_sl_s;
    end

    assign w_z = (w_sum_full == '0);
    assign w_n = w_sum_full[WIDTH-1];
    assign w_v = ( r_a[WIDTH-1] &  r_b[WIDTH-1] & ~w_sum_full[WIDTH-1]) |
                 (~r_a[WIDTH-1] & ~r_b[WIDTH-1] &  w_sum_full[WIDTH-1]);

    always_comb begin
        w_y = w_sum_full;
        case (r_op)
            OP_CMPEQ: w_y = {{(WIDTH-1){1'b0}}, w_z};
            OP_CMPLT: w_y = {{(WIDTH-1){1'b0}}, w_n ^ w_v};
            OP_CMPLE: w_y = {{(WIDTH-1){1'b0}}, w_z | (w_n ^ w_v)};
            default:  w_y = w_sum_full;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_op    <= OP_ADD;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_y     <= '0;
            r_z     <= 1'b0;
            r_v     <= 1'b0;
            r_n     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{w_sub}};
                        r_op    <= op;
                        r_carry <= w_sub;   // +1 completes two's complement
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum[r_idx*SLICE +: SLICE] <= w_sl_s;
                    r_carry <= w_sl_co;
                    if (w_last) begin
                        r_idx <= '0;
                        r_y   <= w_y;
                        r_z   <= w_z;
                        r_v   <= w_v;
                        r_n   <= w_n;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign y         = r_y;
    assign z         = r_z;
    assign v         = r_v;
    assign n         = r_n;

endmodule
`default_nettype wire
